// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter owner for the five-stage core. It advances the word-addressed
// PC, redirects fetch on a taken branch and raises a fixed-length squash pulse
// for the IF/ID slots. It also freezes on hazard stalls and parks in HALT until
// reset.
//
// Ports:
//   clk              in   core clock, rising edge
//   rst              in   asynchronous active-high reset
//   stall_in         in   hazard stall: freezes PC and flush counter
//   branch_sel_in    in   taken-branch strobe (one cycle per resolved branch)
//   branch_target_in in   branch target, valid with branch_sel_in
//   halt_in          in   HALT decoded in EX
//   pc_out           out  current fetch address (registered)
//   pc_plus1_out     out  pc_out + 1, wrapping (combinational)
//   flush_out        out  squash IF/ID valid bits (registered)
//   fetch_valid_out  out  imem read enable / IF valid (combinational)
//   halted_out       out  core halted (registered)
//   state_dbg_out    out  FSM state for observation (0 RUN, 1 FLUSH, 2 HALT)
//
// Handshake: there is no valid/ready pair here. branch_sel_in is a one-cycle
// strobe that is consumed on the edge it is sampled. fetch_valid_out is a
// qualifier and there is no back-pressure on it.
//
// FLUSH_CYCLES must lie in 1..7 because it has to fit the 3-bit counter.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            branch_sel_in,
    input  logic [PC_W-1:0] branch_target_in,
    input  logic            halt_in,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus1_out,
    output logic            flush_out,
    output logic            fetch_valid_out,
    output logic            halted_out,
    output logic [1:0]      state_dbg_out
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            flush_q, flush_d;
    logic            halted_q, halted_d;

    // State register: every piece of sequential state lives here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            cnt_q    <= 3'd0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        flush_d  = flush_q;
        halted_d = halted_q;
        case (state_q)
            ST_RUN: begin
                // A taken branch outranks both halt and stall. The HALT in EX
                // is then on the wrong path or older than the branch.
                if (branch_sel_in) begin
                    pc_d    = branch_target_in;
                    cnt_d   = FLUSH_INIT;
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
                end else if (halt_in) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (!stall_in) begin
                    pc_d = pc_plus1_out;
                end
            end
            ST_FLUSH: begin
                // Branch and halt requests here come from squashed slots, so
                // they are ignored. Fetch keeps walking the target path while
                // the counter drains.
                if (!stall_in) begin
                    pc_d  = pc_plus1_out;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        flush_d = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                // Sticky: only reset leaves HALT.
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        pc_out          = pc_q;
        pc_plus1_out    = pc_q + PC_ONE;
        flush_out       = flush_q;
        halted_out      = halted_q;
        fetch_valid_out = (state_q != ST_HALT) && !stall_in && !rst;
        state_dbg_out   = state_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall_in;
  logic        branch_sel_in;
  logic        halt_in;
  logic [31:0] tgt;

  logic [31:0] pc32, p1_32;
  logic        flush32, fv32, halt32;
  logic [1:0]  st32;
  logic [3:0]  pc4, p1_4;
  logic        flush4, fv4, halt4;
  logic [1:0]  st4;

  pc_sequencer #(.PC_W(32), .RESET_PC(32'd0), .FLUSH_CYCLES(2)) u_dut32 (
    .clk(clk), .rst(rst), .stall_in(stall_in), .branch_sel_in(branch_sel_in),
    .branch_target_in(tgt), .halt_in(halt_in),
    .pc_out(pc32), .pc_plus1_out(p1_32), .flush_out(flush32),
    .fetch_valid_out(fv32), .halted_out(halt32), .state_dbg_out(st32)
  );

  pc_sequencer #(.PC_W(4), .RESET_PC(4'd0), .FLUSH_CYCLES(3)) u_dut4 (
    .clk(clk), .rst(rst), .stall_in(stall_in), .branch_sel_in(branch_sel_in),
    .branch_target_in(tgt[3:0]), .halt_in(halt_in),
    .pc_out(pc4), .pc_plus1_out(p1_4), .flush_out(flush4),
    .fetch_valid_out(fv4), .halted_out(halt4), .state_dbg_out(st4)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Index 0 models the 32-bit instance, index 1 models the 4-bit instance.
  longint unsigned m_pc [2];
  int              m_rem[2];
  bit              m_halt[2];
  int              fc   [2] = '{2, 3};
  longint unsigned mask [2] = '{64'hFFFF_FFFF, 64'hF};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]   = 0;
      m_rem[i]  = 0;
      m_halt[i] = 1'b0;
    end
  endtask

  // One rising edge of behaviour: branch beats halt beats stall. While a
  // squash is pending only the countdown matters. Halt is sticky.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (m_halt[i]) begin
      end else if (m_rem[i] > 0) begin
        if (!stall_in) begin
          m_rem[i]--;
          m_pc[i] = (m_pc[i] + 1) % 64'h1_0000_0000;
        end
      end else if (branch_sel_in) begin
        m_pc[i]  = tgt;
        m_rem[i] = fc[i];
      end else if (halt_in) begin
        m_halt[i] = 1'b1;
      end else if (!stall_in) begin
        m_pc[i] = (m_pc[i] + 1) % 64'h1_0000_0000;
      end
      exp_q.push_back(32'(m_pc[i] & mask[i]));
    end
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "/flush32"}, flush32, m_rem[0] > 0);
    check_eq({tag, "/flush4"},  flush4,  m_rem[1] > 0);
    check_eq({tag, "/halt32"},  halt32,  m_halt[0]);
    check_eq({tag, "/halt4"},   halt4,   m_halt[1]);
    check_eq({tag, "/fv32"},    fv32,    !m_halt[0] && !stall_in && !rst);
    check_eq({tag, "/fv4"},     fv4,     !m_halt[1] && !stall_in && !rst);
    check_eq({tag, "/p1_32"},   p1_32,   (m_pc[0] + 1) & mask[0]);
    check_eq({tag, "/p1_4"},    p1_4,    (m_pc[1] + 1) & mask[1]);
  endtask

  task automatic check_pc(input string tag);
    logic [31:0] e;
    if (exp_q.size() < 2) begin
      check_eq({tag, "/exp_q_underflow"}, 64'(exp_q.size()), 64'd2);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "/pc32"}, pc32, e);
      e = exp_q.pop_front();
      check_eq({tag, "/pc4"}, pc4, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; returns just after the next one.
  task automatic cycle(input bit st, input bit br, input bit ht,
                       input logic [31:0] t, input string tag);
    stall_in      = st;
    branch_sel_in = br;
    halt_in       = ht;
    tgt           = t;
    #1;
    check_flags({tag, "/pre"});
    @(posedge clk);
    model_edge();
    #1;
    check_pc(tag);
    check_flags(tag);
  endtask

  task automatic free_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 32'd0, tag);
  endtask

  // Reset asserted between edges; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq({tag, "/pc32_now"},    pc32,    64'd0);
    check_eq({tag, "/pc4_now"},     pc4,     64'd0);
    check_eq({tag, "/flush32_now"}, flush32, 64'd0);
    check_eq({tag, "/flush4_now"},  flush4,  64'd0);
    check_eq({tag, "/halt32_now"},  halt32,  64'd0);
    check_eq({tag, "/fv32_now"},    fv32,    64'd0);
    stall_in      = 1'b0;
    branch_sel_in = 1'b0;
    halt_in       = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "/pc32_held"}, pc32, 64'd0);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    stall_in      = 1'b0;
    branch_sel_in = 1'b0;
    halt_in       = 1'b0;
    tgt           = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst/pc32", pc32, 64'd0);
    check_flags("rst");

    // Reset and increment.
    free_cycles(5, "inc");
    check_eq("inc/pc32_is_5", pc32, 64'd5);
    check_eq("inc/p1_32_is_6", p1_32, 64'd6);

    // Taken branch at pc=10.
    free_cycles(5, "to10");
    check_eq("to10/pc32", pc32, 64'd10);
    cycle(1'b0, 1'b1, 1'b0, 32'h40, "br");
    check_eq("br/pc32_40", pc32, 64'h40);
    check_eq("br/flush32_1", flush32, 64'd1);
    free_cycles(1, "br_f2");
    check_eq("br_f2/pc32_41", pc32, 64'h41);
    check_eq("br_f2/flush32_1", flush32, 64'd1);
    free_cycles(1, "br_end");
    check_eq("br_end/pc32_42", pc32, 64'h42);
    check_eq("br_end/flush32_0", flush32, 64'd0);
    free_cycles(2, "drain");

    // Branch coincident with stall and halt: branch wins.
    cycle(1'b1, 1'b1, 1'b1, 32'h80, "br_st_ht");
    check_eq("br_st_ht/pc32", pc32, 64'h80);
    check_eq("br_st_ht/halt32", halt32, 64'd0);
    check_eq("br_st_ht/flush32", flush32, 64'd1);

    // Stall inside FLUSH, then a branch that must be ignored.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 32'd0, "fl_stall");
    check_eq("fl_stall/pc32", pc32, 64'h80);
    check_eq("fl_stall/flush32", flush32, 64'd1);
    cycle(1'b0, 1'b1, 1'b0, 32'h200, "fl_br");
    check_eq("fl_br/pc32_81", pc32, 64'h81);
    free_cycles(1, "fl_end");
    check_eq("fl_end/pc32_82", pc32, 64'h82);
    check_eq("fl_end/flush32_0", flush32, 64'd0);
    free_cycles(3, "drain2");

    // Halt at pc=7.
    async_reset("rst2");
    free_cycles(7, "to7");
    cycle(1'b0, 1'b0, 1'b1, 32'd0, "halt");
    check_eq("halt/pc32_7", pc32, 64'd7);
    check_eq("halt/halted32", halt32, 64'd1);
    check_eq("halt/fv32", fv32, 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h99, "halt_br");
    check_eq("halt_br/pc32_7", pc32, 64'd7);
    free_cycles(2, "halt_idle");
    async_reset("halt_rst");

    // Wrap on the 4-bit instance, then reset in the middle of a flush.
    free_cycles(14, "to14");
    check_eq("to14/pc4", pc4, 64'd14);
    free_cycles(1, "to15");
    check_eq("to15/pc4", pc4, 64'd15);
    check_eq("to15/p1_4_wrap", p1_4, 64'd0);
    free_cycles(1, "wrap");
    check_eq("wrap/pc4_0", pc4, 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h33, "br_pre_rst");
    async_reset("flush_rst");
    free_cycles(1, "post_rst");

    // Randomized traffic, including high targets to exercise 32-bit wrap.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) < 2) begin
        async_reset("rnd_rst");
      end else begin
        cycle($urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 12,
              $urandom_range(0, 99) < 3,
              ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                          : $urandom,
              "rnd");
      end
    end

    check_eq("final/exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter for the five-stage core. It consumes the registered branch-taken strobe and its aligned target, and redirects fetch. After a redirect it emits a fixed-length squash pulse so IF/ID discard wrong-path instructions. It also handles pipeline stalls and the HALT opcode.

Parameters:
PC_W, 32, PC width in bits; PC is word-addressed, increment is 1.
RESET_PC, 0, PC value loaded on reset.
FLUSH_CYCLES, 2, number of cycles flush_out stays high after a taken branch (IF and ID slots); legal range 1..7.

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stall_in  input  1  hazard stall; freezes PC and flush counter
branch_sel_in  input  1  taken-branch strobe from branch resolution, one cycle per resolved branch
branch_target_in  input  PC_W  branch target; valid only in the cycle branch_sel_in=1
halt_in  input  1  HALT decoded in EX
pc_out  output  PC_W  current fetch address (registered)
pc_plus1_out  output  PC_W  pc_out+1 mod 2^PC_W (combinational), used for link/fall-through
flush_out  output  1  squash IF/ID valid bits (registered)
fetch_valid_out  output  1  instruction memory read enable / IF valid
halted_out  output  1  core halted (registered)

Behaviour:
- Reset, asynchronous on rst=1:
  - pc_out=RESET_PC, state=RUN, flush counter=0.
  - flush_out=0, halted_out=0.
  - fetch_valid_out=0 while rst=1.
- States: RUN, FLUSH, HALT. A 3-bit counter holds the remaining flush cycles.
- RUN, priority order:
  1. branch_sel_in=1: pc_out<=branch_target_in; state<=FLUSH; counter<=FLUSH_CYCLES; flush_out<=1. This happens regardless of stall_in and halt_in (branch wins).
  2. Else halt_in=1: pc_out holds; state<=HALT; halted_out<=1.
  3. Else stall_in=1: pc_out holds.
  4. Else pc_out<=pc_out+1.
- FLUSH:
  - flush_out=1 for exactly FLUSH_CYCLES non-stalled cycles, starting the cycle after the branch_sel_in edge.
  - Each non-stalled cycle: counter decrements and pc_out increments (fetching from the target path).
  - stall_in=1: counter, pc_out and flush_out all hold.
  - When the counter reaches 0: flush_out<=0 and state<=RUN on that same edge.
  - branch_sel_in and halt_in are ignored in FLUSH, because they originate from squashed slots.
- HALT:
  - pc_out holds; fetch_valid_out=0; halted_out=1.
  - All inputs are ignored. The only exit is rst.
- fetch_valid_out = (state!=HALT) and not stall_in and not rst. It is combinational.
- Arithmetic: PC increment wraps from 2^PC_W-1 to 0 with no flag. pc_plus1_out wraps identically.
- Latency: redirect takes effect on pc_out one cycle after branch_sel_in is sampled. There is no bubble beyond the squashed slots.
- Reset mid-FLUSH or mid-HALT aborts immediately to reset values. No residual flush pulse.

Test Plan:
1. Reset and increment: assert rst, release. Expect pc_out=0, flush_out=0, halted_out=0, fetch_valid_out=1. Then 5 free cycles give pc_out=5, and pc_plus1_out=6.
2. Taken branch: at pc=10, pulse branch_sel_in with target=0x40. Expect next cycle pc_out=0x40 and flush_out=1 for exactly 2 cycles (pc 0x40, 0x41). Then flush_out=0 with pc=0x42.
3. Branch coincident with stall_in=1 and halt_in=1: redirect to target, state FLUSH, halted_out stays 0.
4. Stall during FLUSH (FLUSH_CYCLES=2): stall on the first flush cycle for 3 cycles. Expect pc_out and flush_out frozen, then 2 more flush cycles. A branch_sel_in pulse inside FLUSH is ignored: pc_out does not jump to the new target.
5. Halt: at pc=7 assert halt_in. Expect pc_out frozen at 7, fetch_valid_out=0, halted_out=1. Later branch_sel_in has no effect. rst returns pc_out to 0.
6. Wrap and async reset: with PC_W=4, run from 14 to give 15, then 0, with pc_plus1_out=0 when pc=15. Assert rst mid-FLUSH, between clock edges. Expect outputs at reset values immediately, before the next edge.
